// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, issues one instruction-memory read at a
// time and hands the fetched word and its PC to decode over a valid/ready handshake.
module instr_fetch #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_resp_valid,
   input  logic [DATA_WIDTH-1:0] imem_resp_data,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   input  logic                  PCsrc,
   input  logic [ADDR_WIDTH-1:0] ImmOp,
   output logic                  fault,
   output logic [31:0]           fetch_count
);

   localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

   typedef enum logic [1:0] {REQ, WAIT, HOLD, FAULT} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic                    consume;
   logic                    misaligned;
   logic [ADDR_WIDTH-1:0]   next_pc;

   // Offset is a sign-extended immediate; the sum wraps modulo 2^ADDR_WIDTH.
   function automatic logic [ADDR_WIDTH-1:0] target_pc(
      input logic        [ADDR_WIDTH-1:0] cur,
      input logic                         taken,
      input logic signed [ADDR_WIDTH-1:0] offs
   );
      logic signed [ADDR_WIDTH-1:0] step;
      step = taken ? offs : ADDR_WIDTH'(4);
      return cur + $unsigned(step);
   endfunction

   assign consume    = instr_valid & instr_ready;
   assign next_pc    = target_pc(pc, PCsrc, ImmOp);
   assign misaligned = |next_pc[1:0];
   assign imem_addr  = pc;

   always_comb begin
      state_nxt = state;
      unique case (state)
         REQ:   if (imem_req_valid && imem_req_ready) state_nxt = WAIT;
         WAIT:  if (imem_resp_valid) state_nxt = HOLD;
         HOLD:  if (consume) state_nxt = misaligned ? FAULT : REQ;
         FAULT: state_nxt = FAULT;
      endcase
   end

   // Handshake flags are registered from the next state so no input reaches an output.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= REQ;
         pc             <= RESET_PC;
         instr          <= NOP;
         imem_req_valid <= 1'b0;
         instr_valid    <= 1'b0;
         fault          <= 1'b0;
         fetch_count    <= 32'd0;
      end else begin
         state          <= state_nxt;
         imem_req_valid <= (state_nxt == REQ);
         instr_valid    <= (state_nxt == HOLD);
         fault          <= fault | (state_nxt == FAULT);
         if (state == WAIT && imem_resp_valid) instr <= imem_resp_data;
         if (consume) begin
            fetch_count <= fetch_count + 32'd1;
            if (!misaligned) pc <= next_pc;
         end
      end
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the single-cycle RISC-V core. Holds the program counter, issues one instruction-memory read at a time over a valid/ready request and valid response interface, and presents the fetched word and its PC to the decode/control stage with a valid/ready handshake. The next PC is computed when decode accepts an instruction: the branch target PC + ImmOp when decode asserts `PCsrc`, otherwise PC + 4.

## Interface
Parameters:
- `DATA_WIDTH`, 32, instruction word width.
- `ADDR_WIDTH`, 32, PC / instruction-memory address width.
- `RESET_PC`, 0, PC loaded on reset. Must be word-aligned.

Ports:
- `clk`  in  1  single clock. All state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `imem_req_valid`  out  1  read request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_addr`  out  ADDR_WIDTH  read address. Equals `pc`.
- `imem_resp_valid`  in  1  read data valid.
- `imem_resp_data`  in  DATA_WIDTH  read data.
- `instr`  out  DATA_WIDTH  fetched instruction, to control unit and register file.
- `pc`  out  ADDR_WIDTH  address of `instr`.
- `instr_valid`  out  1  `instr` and `pc` are valid.
- `instr_ready`  in  1  decode consumes `instr` this cycle.
- `PCsrc`  in  1  branch taken for the instruction being consumed. Sampled only when it is consumed.
- `ImmOp`  in  ADDR_WIDTH  sign-extended branch offset. Sampled together with `PCsrc`.
- `fault`  out  1  sticky flag for a misaligned next PC.
- `fetch_count`  out  32  number of instructions consumed. Wraps modulo 2^32.

## Operation
- FSM states: REQ, WAIT, HOLD, FAULT.
- **REQ**
  - `imem_req_valid`=1.
  - On `imem_req_valid & imem_req_ready`, go to WAIT.
  - `imem_addr` and `pc` stay stable while waiting for `imem_req_ready`.
- **WAIT**
  - `imem_req_valid`=0.
  - On `imem_resp_valid`, latch `imem_resp_data` into `instr` and go to HOLD.
- **HOLD**
  - `instr_valid`=1. `instr` and `pc` are held stable.
  - On `instr_valid & instr_ready` (consume):
    - `fetch_count` increments by 1.
    - next_pc = `PCsrc` ? `pc` + `ImmOp` : `pc` + 4. The addition is modulo 2^ADDR_WIDTH, so overflow wraps silently.
    - If next_pc[1:0] != 0: go to FAULT and leave `pc` unchanged.
    - Otherwise: `pc` <= next_pc and go to REQ.
- **FAULT**
  - `fault`=1. No requests are issued. `instr_valid`=0.
  - Only reset exits this state.
- `imem_resp_valid` outside WAIT is ignored. `PCsrc`/`ImmOp` outside a consume cycle are ignored.
- One outstanding memory request at most.
- Reset values when `rst_n`=0 at a rising edge:
  - state = REQ, `pc` = `RESET_PC`.
  - `instr` = 0x00000013 (NOP, addi x0,x0,0).
  - `instr_valid` = 0, `fault` = 0, `fetch_count` = 0.
  - `imem_req_valid` is 0 during the reset cycle.
- Reset mid-operation (any state) abandons the in-flight request. Instruction memory shares `rst_n` and drops its pending response.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- First request: `imem_req_valid`=1 in the first cycle after the cycle in which `rst_n` is seen high.
- Zero-wait memory (ready and response in the cycle right after acceptance): REQ 1 cycle, WAIT 1 cycle, HOLD ≥1 cycle. Best-case throughput is one instruction per 3 cycles.
- `instr_valid` rises in the cycle after the `imem_resp_valid` edge. It falls in the cycle after the consume.
- A request for the new `pc` is visible in the cycle after the consume.
- `fault` rises in the cycle after the faulting consume. The faulting instruction is still counted in `fetch_count`.
- Back-pressure: `instr_ready`=0 holds HOLD indefinitely, with no change to any output.

## Test plan
- **Reset and sequential fetch.** Deassert `rst_n` with `RESET_PC`=0 and zero-wait memory returning addr+0x100, `instr_ready`=1. Required:
  - Requests at 0x0, 0x4, 0x8.
  - `instr` 0x100, 0x104, 0x108.
  - `fetch_count`=3 after the third consume.
- **Taken branch.** At `pc`=0x8, consume with `PCsrc`=1 and `ImmOp`=0xFFFFFFF8. Required: next request at 0x0. With `PCsrc`=0: next request at 0xC.
- **Stalls.** Hold `imem_req_ready`=0 for 4 cycles, delay the response by 3 cycles, and hold `instr_ready`=0 for 5 cycles. Required:
  - `imem_addr`, `instr`, `pc` stable throughout.
  - No duplicate request.
  - Spurious `imem_resp_valid` pulses in REQ/HOLD do not change `instr`.
- **Misaligned target.** Consume with `PCsrc`=1 and `ImmOp`=0x2. Required:
  - `fault`=1 next cycle.
  - `imem_req_valid` stays 0 for the next 10 cycles.
  - `pc` unchanged.
  - `fetch_count` incremented.
- **Reset mid-WAIT.** Pulse `rst_n` low for 1 cycle while in WAIT at `pc`=0x10. Required:
  - `pc`=0, `instr_valid`=0, `instr`=0x00000013, `fetch_count`=0.
  - New request at 0x0 in the cycle after release.
- **Wrap.** Preload `pc`=0xFFFFFFFC via `RESET_PC` and consume with `PCsrc`=0. Required: next request at 0x00000000, with no fault.
